// File: rtl/ysyx_22050598_mem_bridge_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ysyx_22050598_mem_bridge_if: LSU request/response + data-bus port  |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
interface ysyx_22050598_mem_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  logic        bus_valid;
  logic        bus_ready;
  logic        bus_wen;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_rsp_valid;
  logic        bus_rsp_err;
  logic [63:0] bus_rdata;

  // Environment side: the load/store unit plus the memory it talks to.
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    output rsp_ready,
    output bus_ready, bus_rsp_valid, bus_rsp_err, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_valid, bus_wen, bus_addr, bus_wdata, bus_wmask
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    input  rsp_ready,
    input  bus_ready, bus_rsp_valid, bus_rsp_err, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_valid, bus_wen, bus_addr, bus_wdata, bus_wmask
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050598_mem_bridge.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ysyx_22050598_mem_bridge: one-at-a-time LSU to data-bus bridge     |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module ysyx_22050598_mem_bridge #(
  parameter int TO_W      = 8,
  parameter int TO_CYCLES = 255
) (
  input  wire                              clk,
  input  wire                              rst_n,
  ysyx_22050598_mem_bridge_if.slave        mb_io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_CYCLES);

  state_e          state_q;
  logic [TO_W-1:0] cnt_q;
  logic [2:0]      off_q;
  logic [1:0]      size_q;
  logic            uns_q;

  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [63:0]     rsp_rdata_q;
  logic            bus_valid_q;
  logic            bus_wen_q;
  logic [63:0]     bus_addr_q;
  logic [63:0]     bus_wdata_q;
  logic [7:0]      bus_wmask_q;

  logic            misalign_d;
  logic [63:0]     wdata_d;
  logic [7:0]      mask_base_d;
  logic [7:0]      wmask_d;
  logic [63:0]     shifted_d;
  logic [63:0]     rdata_fmt_d;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    misalign_d  = 1'b0;
    wdata_d     = mb_io.req_wdata;
    mask_base_d = 8'hFF;
    unique case (mb_io.req_size)
      2'b00: begin
        wdata_d     = {8{mb_io.req_wdata[7:0]}};
        mask_base_d = 8'h01;
      end
      2'b01: begin
        wdata_d     = {4{mb_io.req_wdata[15:0]}};
        mask_base_d = 8'h03;
        misalign_d  = mb_io.req_addr[0];
      end
      2'b10: begin
        wdata_d     = {2{mb_io.req_wdata[31:0]}};
        mask_base_d = 8'h0F;
        misalign_d  = (mb_io.req_addr[1:0] != 2'b00);
      end
      default: begin
        wdata_d     = mb_io.req_wdata;
        mask_base_d = 8'hFF;
        misalign_d  = (mb_io.req_addr[2:0] != 3'b000);
      end
    endcase
    wmask_d = mb_io.req_wen ? (mask_base_d << mb_io.req_addr[2:0]) : 8'h00;
  end

  // Doubleword loads are always aligned, so the shift is zero and they pass through.
  always_comb begin
    shifted_d   = mb_io.bus_rdata >> {off_q, 3'b000};
    rdata_fmt_d = shifted_d;
    unique case (size_q)
      2'b00:   rdata_fmt_d = uns_q ? {56'd0, shifted_d[7:0]}
                                   : {{56{shifted_d[7]}}, shifted_d[7:0]};
      2'b01:   rdata_fmt_d = uns_q ? {48'd0, shifted_d[15:0]}
                                   : {{48{shifted_d[15]}}, shifted_d[15:0]};
      2'b10:   rdata_fmt_d = uns_q ? {32'd0, shifted_d[31:0]}
                                   : {{32{shifted_d[31]}}, shifted_d[31:0]};
      default: rdata_fmt_d = shifted_d;
    endcase
    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      off_q       <= 3'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 64'd0;
      bus_valid_q <= 1'b0;
      bus_wen_q   <= 1'b0;
      bus_addr_q  <= 64'd0;
      bus_wdata_q <= 64'd0;
      bus_wmask_q <= 8'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (mb_io.req_valid) begin
            bus_wen_q   <= mb_io.req_wen;
            bus_addr_q  <= {mb_io.req_addr[63:3], 3'b000};
            bus_wdata_q <= wdata_d;
            bus_wmask_q <= wmask_d;
            off_q       <= mb_io.req_addr[2:0];
            size_q      <= mb_io.req_size;
            uns_q       <= mb_io.req_unsigned;
            if (misalign_d) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 64'd0;
            end else begin
              state_q     <= S_REQ;
              bus_valid_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mb_io.bus_ready) begin
            state_q     <= S_WAIT;
            bus_valid_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          // A response on the expiry cycle takes priority over the timeout.
          if (mb_io.bus_rsp_valid) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= mb_io.bus_rsp_err;
            rsp_rdata_q <= (mb_io.bus_rsp_err || bus_wen_q) ? 64'd0 : rdata_fmt_d;
          end else if (cnt_d == TO_LIMIT) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 64'd0;
          end
        end
        S_RESP: begin
          if (mb_io.rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mb_io.req_ready = (state_q == S_IDLE);
  assign mb_io.rsp_valid = rsp_valid_q;
  assign mb_io.rsp_err   = rsp_err_q;
  assign mb_io.rsp_rdata = rsp_rdata_q;
  assign mb_io.bus_valid = bus_valid_q;
  assign mb_io.bus_wen   = bus_wen_q;
  assign mb_io.bus_addr  = bus_addr_q;
  assign mb_io.bus_wdata = bus_wdata_q;
  assign mb_io.bus_wmask = bus_wmask_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050598_mem_bridge.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_ysyx_22050598_mem_bridge: directed vectors for the mem bridge   |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module tb_ysyx_22050598_mem_bridge;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ysyx_22050598_mem_bridge_if mb();

  ysyx_22050598_mem_bridge #(
    .TO_W      (8),
    .TO_CYCLES (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mb_io (mb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] brdata;
    logic        berr;
    logic        mis;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_wmask;
    logic [63:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [1:0] size, input logic uns);
    mb.req_valid    = 1'b1;
    mb.req_wen      = wen;
    mb.req_addr     = addr;
    mb.req_wdata    = wdata;
    mb.req_size     = size;
    mb.req_unsigned = uns;
  endtask

  // Response arrives in the second WAIT cycle, so rsp_valid shows 3 edges after accept.
  task automatic run_vec(input vec_t v, input string tag);
    mb.bus_ready = 1'b1;
    mb.rsp_ready = 1'b0;
    chk({tag, " req_ready"}, 64'(mb.req_ready), 64'd1);
    drive_req(v.wen, v.addr, v.wdata, v.size, v.uns);
    tick();
    mb.req_valid = 1'b0;
    if (v.mis) begin
      chk({tag, " mis bus_valid"}, 64'(mb.bus_valid), 64'd0);
      chk({tag, " mis rsp_valid"}, 64'(mb.rsp_valid), 64'd1);
      chk({tag, " mis rsp_err"}, 64'(mb.rsp_err), 64'd1);
      chk({tag, " mis rsp_rdata"}, mb.rsp_rdata, 64'd0);
    end else begin
      chk({tag, " bus_valid"}, 64'(mb.bus_valid), 64'd1);
      chk({tag, " bus_addr"}, mb.bus_addr, v.e_addr);
      chk({tag, " bus_wen"}, 64'(mb.bus_wen), 64'(v.wen));
      chk({tag, " bus_wdata"}, mb.bus_wdata, v.e_wdata);
      chk({tag, " bus_wmask"}, 64'(mb.bus_wmask), 64'(v.e_wmask));
      tick();
      chk({tag, " bus_valid drop"}, 64'(mb.bus_valid), 64'd0);
      tick();
      chk({tag, " early rsp"}, 64'(mb.rsp_valid), 64'd0);
      mb.bus_rsp_valid = 1'b1;
      mb.bus_rsp_err   = v.berr;
      mb.bus_rdata     = v.brdata;
      tick();
      mb.bus_rsp_valid = 1'b0;
      mb.bus_rsp_err   = 1'b0;
      chk({tag, " rsp_valid"}, 64'(mb.rsp_valid), 64'd1);
      chk({tag, " rsp_rdata"}, mb.rsp_rdata, v.e_rdata);
      chk({tag, " rsp_err"}, 64'(mb.rsp_err), 64'(v.e_err));
    end
    mb.rsp_ready = 1'b1;
    tick();
    mb.rsp_ready = 1'b0;
    chk({tag, " rsp_valid clear"}, 64'(mb.rsp_valid), 64'd0);
  endtask

  initial begin
    int          beats;
    logic [63:0] held;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    mb.req_valid = 1'b0; mb.req_wen = 1'b0; mb.req_addr = 64'd0; mb.req_wdata = 64'd0;
    mb.req_size = 2'd0; mb.req_unsigned = 1'b0; mb.rsp_ready = 1'b0; mb.bus_ready = 1'b0;
    mb.bus_rsp_valid = 1'b0; mb.bus_rsp_err = 1'b0; mb.bus_rdata = 64'd0;

    //          wen   addr                    wdata                   sz    uns   brdata                  berr  mis   e_addr                  e_wdata                 e_wmask e_rdata                 e_err
    vecs[0]  = '{1'b0, 64'h0000_0000_8000_0003, 64'd0,                  2'd0, 1'b0, 64'h0000_0000_80FF_0000, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'd0,                  8'h00, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    vecs[1]  = '{1'b1, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_BEEF, 2'd1, 1'b0, 64'h0000_0000_0000_1234, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'hBEEF_BEEF_BEEF_BEEF, 8'hC0, 64'd0,                  1'b0};
    vecs[2]  = '{1'b0, 64'h0000_0000_8000_0002, 64'd0,                  2'd2, 1'b0, 64'd0,                  1'b0, 1'b1, 64'd0,                  64'd0,                  8'h00, 64'd0,                  1'b1};
    vecs[3]  = '{1'b0, 64'h0000_0000_8000_0002, 64'd0,                  2'd1, 1'b1, 64'h0000_0000_ABCD_1234, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'd0,                  8'h00, 64'h0000_0000_0000_ABCD, 1'b0};
    vecs[4]  = '{1'b0, 64'h0000_0000_8000_0002, 64'd0,                  2'd1, 1'b0, 64'h0000_0000_ABCD_1234, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'd0,                  8'h00, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0};
    vecs[5]  = '{1'b1, 64'h0000_0000_8000_0004, 64'h0000_0000_1122_3344, 2'd2, 1'b0, 64'd0,                  1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h1122_3344_1122_3344, 8'hF0, 64'd0,                  1'b0};
    vecs[6]  = '{1'b1, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_00A5, 2'd0, 1'b0, 64'd0,                  1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'hA5A5_A5A5_A5A5_A5A5, 8'h20, 64'd0,                  1'b0};
    vecs[7]  = '{1'b1, 64'h0000_0000_8000_0008, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0, 64'd0,                  1'b0, 1'b0, 64'h0000_0000_8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0,                  1'b0};
    vecs[8]  = '{1'b0, 64'h0000_0000_8000_0001, 64'd0,                  2'd3, 1'b0, 64'd0,                  1'b0, 1'b1, 64'd0,                  64'd0,                  8'h00, 64'd0,                  1'b1};
    vecs[9]  = '{1'b0, 64'h0000_0000_8000_0001, 64'd0,                  2'd1, 1'b0, 64'd0,                  1'b0, 1'b1, 64'd0,                  64'd0,                  8'h00, 64'd0,                  1'b1};
    vecs[10] = '{1'b0, 64'h0000_0000_8000_0004, 64'd0,                  2'd2, 1'b0, 64'h8000_0001_0000_0000, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'd0,                  8'h00, 64'hFFFF_FFFF_8000_0001, 1'b0};
    vecs[11] = '{1'b0, 64'h0000_0000_8000_0007, 64'd0,                  2'd0, 1'b1, 64'hFE00_0000_0000_0000, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'd0,                  8'h00, 64'h0000_0000_0000_00FE, 1'b0};
    vecs[12] = '{1'b0, 64'h0000_0000_8000_0010, 64'd0,                  2'd3, 1'b0, 64'h5555_6666_7777_8888, 1'b1, 1'b0, 64'h0000_0000_8000_0010, 64'd0,                  8'h00, 64'd0,                  1'b1};
    vecs[13] = '{1'b0, 64'h0000_0000_8000_0004, 64'd0,                  2'd2, 1'b1, 64'hF000_0000_0000_0000, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'd0,                  8'h00, 64'h0000_0000_F000_0000, 1'b0};

    #12;
    chk("rst req_ready", 64'(mb.req_ready), 64'd1);
    chk("rst rsp_valid", 64'(mb.rsp_valid), 64'd0);
    chk("rst bus_valid", 64'(mb.bus_valid), 64'd0);
    chk("rst bus_wen", 64'(mb.bus_wen), 64'd0);
    chk("rst bus_addr", mb.bus_addr, 64'd0);
    chk("rst bus_wdata", mb.bus_wdata, 64'd0);
    chk("rst bus_wmask", 64'(mb.bus_wmask), 64'd0);
    chk("rst rsp_rdata", mb.rsp_rdata, 64'd0);
    chk("rst rsp_err", 64'(mb.rsp_err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure on both handshakes: one beat, fields held stable.
    beats = 0;
    mb.bus_ready = 1'b0;
    drive_req(1'b0, 64'h0000_0000_8000_0020, 64'd0, 2'd3, 1'b0);
    tick();
    mb.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mb.bus_valid && mb.bus_ready) beats++;
      tick();
      chk("bp bus_valid", 64'(mb.bus_valid), 64'd1);
      chk("bp bus_addr", mb.bus_addr, 64'h0000_0000_8000_0020);
      chk("bp bus_wmask", 64'(mb.bus_wmask), 64'd0);
    end
    mb.bus_ready = 1'b1;
    if (mb.bus_valid && mb.bus_ready) beats++;
    tick();
    mb.bus_rsp_valid = 1'b1;
    mb.bus_rdata     = 64'hDEAD_BEEF_CAFE_F00D;
    if (mb.bus_valid && mb.bus_ready) beats++;
    tick();
    mb.bus_rsp_valid = 1'b0;
    mb.bus_rdata     = 64'd0;
    for (int i = 0; i < 3; i++) begin
      if (mb.bus_valid && mb.bus_ready) beats++;
      chk("bp rsp_valid", 64'(mb.rsp_valid), 64'd1);
      chk("bp rsp_rdata", mb.rsp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
      chk("bp rsp_err", 64'(mb.rsp_err), 64'd0);
      tick();
    end
    chk("bp beats", 64'(beats), 64'd1);
    mb.rsp_ready = 1'b1;
    tick();
    mb.rsp_ready = 1'b0;
    chk("bp done", 64'(mb.req_ready), 64'd1);

    // Timeout after 4 WAIT cycles, then late responses are ignored.
    drive_req(1'b0, 64'h0000_0000_8000_0000, 64'd0, 2'd2, 1'b0);
    tick();
    mb.req_valid = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("to early %0d", i), 64'(mb.rsp_valid), 64'd0);
    end
    tick();
    chk("to rsp_valid", 64'(mb.rsp_valid), 64'd1);
    chk("to rsp_err", 64'(mb.rsp_err), 64'd1);
    chk("to rsp_rdata", mb.rsp_rdata, 64'd0);
    mb.bus_rsp_valid = 1'b1;
    mb.bus_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mb.bus_rsp_valid = 1'b0;
    chk("late err held", 64'(mb.rsp_err), 64'd1);
    chk("late rdata held", mb.rsp_rdata, 64'd0);
    mb.rsp_ready = 1'b1;
    tick();
    mb.rsp_ready = 1'b0;
    mb.bus_rsp_valid = 1'b1;
    tick();
    mb.bus_rsp_valid = 1'b0;
    chk("late idle rsp_valid", 64'(mb.rsp_valid), 64'd0);
    chk("late idle req_ready", 64'(mb.req_ready), 64'd1);

    // Async reset while a bus beat is pending drops bus_valid without a clock.
    mb.bus_ready = 1'b0;
    drive_req(1'b0, 64'h0000_0000_8000_0000, 64'd0, 2'd3, 1'b0);
    tick();
    mb.req_valid = 1'b0;
    chk("rreq bus_valid pre", 64'(mb.bus_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rreq bus_valid", 64'(mb.bus_valid), 64'd0);
    chk("rreq req_ready", 64'(mb.req_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    mb.bus_ready = 1'b1;

    // Async reset in WAIT, then a fresh load.
    drive_req(1'b0, 64'h0000_0000_8000_0008, 64'd0, 2'd3, 1'b0);
    tick();
    mb.req_valid = 1'b0;
    tick();
    chk("rwait req_ready pre", 64'(mb.req_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rwait bus_valid", 64'(mb.bus_valid), 64'd0);
    chk("rwait rsp_valid", 64'(mb.rsp_valid), 64'd0);
    chk("rwait req_ready", 64'(mb.req_ready), 64'd1);
    mb.bus_rsp_valid = 1'b1;
    tick();
    mb.bus_rsp_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rwait no rsp", 64'(mb.rsp_valid), 64'd0);
    run_vec(vecs[13], "post-rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
